// File: rtl/regfile32.sv
`default_nettype none
// ============================================================================
// regfile32 : 32 x 32-bit register file, one synchronous write port, two
//             combinational read ports, register 0 hard-wired to zero.
// Optional define REGFILE_BYPASS_EN : same-cycle write-to-read forwarding.
// Revision  : 1.0
// ============================================================================
module regfile32 #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam int DEPTH = 1 << AW;

  logic                       wr_valid;
  logic [DEPTH-1:0][DW-1:0]   word;
  logic [DW-1:0]              rd1_stored;
  logic [DW-1:0]              rd2_stored;

  assign wr_valid = we && (waddr != '0);

  // Index 0 has no storage at all, so it can never hold anything but zero.
  assign word[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
      data_d = data_q;
      if (wr_valid && (waddr == AW'(i))) begin
        data_d = wdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign word[i] = data_q;
  end

  assign rd1_stored = word[raddr1];
  assign rd2_stored = word[raddr2];

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forwarding is suppressed under reset so the ports read zero while rst_n is low.
  assign fwd1   = rst_n && wr_valid && (raddr1 == waddr);
  assign fwd2   = rst_n && wr_valid && (raddr2 == waddr);
  assign rdata1 = fwd1 ? wdata : rd1_stored;
  assign rdata2 = fwd2 ? wdata : rd2_stored;
`else
  assign rdata1 = rd1_stored;
  assign rdata2 = rd2_stored;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile32.sv
`default_nettype none
// ============================================================================
// tb_regfile32 : scoreboard bench for regfile32; driver queues expected read
//                data, monitor drains and compares on each falling clk edge.
// Revision     : 1.0
// ============================================================================
module tb_regfile32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  regfile32 #(.DW(32), .AW(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, pending=%0d", q.size());
    $fatal(1, "timeout");
  end

  // Monitor: drains every queued expectation against the read ports.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = e.port ? rdata2 : rdata1;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s port%0d: got %h expected %h", e.name, e.port + 1, act, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input string n, input bit p, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.port = p;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step();
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input string n, input logic [4:0] a1, input logic [31:0] e1,
                    input logic [4:0] a2, input logic [31:0] e2);
    raddr1 = a1;
    raddr2 = a2;
    push_exp(n, 1'b0, e1);
    push_exp(n, 1'b1, e2);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;

    rd("reset_state", 5'd0, 32'h0, 5'd31, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    rd("post_reset", 5'd5, 32'h0, 5'd17, 32'h0);

    // T1: populate, then async reset clears everything
    wr(5'd1,  32'h11111111);
    wr(5'd2,  $urandom);
    wr(5'd31, 32'h3131abcd);
    wr(5'd16, $urandom);
    rd("t1_prefill", 5'd1, 32'h11111111, 5'd31, 32'h3131abcd);
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd("t1_reset_all", 5'(i), 32'h0, 5'(31 - i), 32'h0);
    end
    step();
    rst_n = 1'b1;
    step();

    // T2: basic write/read
    wr(5'd5, 32'haaaaaaaa);
    wr(5'd6, 32'hbbbbbbbb);
    rd("t2_write_read", 5'd5, 32'haaaaaaaa, 5'd6, 32'hbbbbbbbb);

    // T3: writes to index 0 are dropped
    wr(5'd0, 32'hffffffff);
    rd("t3_zero_reg", 5'd0, 32'h0, 5'd0, 32'h0);

    // T4: same-cycle write and read of one index
    wr(5'd7, 32'hcccccccc);
    step();
    we    = 1'b1;
    waddr = 5'd7;
    wdata = 32'hdddddddd;
    rd("t4_before_edge", 5'd7, BYP ? 32'hdddddddd : 32'hcccccccc,
                         5'd5, 32'haaaaaaaa);
    step();
    we = 1'b0;
    rd("t4_after_edge", 5'd7, 32'hdddddddd, 5'd7, 32'hdddddddd);

    // T5: both ports on one index, then idle cycles with wdata toggling
    wr(5'd9, 32'heeeeeeee);
    rd("t5_same_index", 5'd9, 32'heeeeeeee, 5'd9, 32'heeeeeeee);
    for (int k = 0; k < 3; k++) begin
      step();
      we    = 1'b0;
      waddr = 5'd9;
      wdata = 32'h01010101 * (k + 1);
      rd("t5_we_low", 5'd9, 32'heeeeeeee, 5'd9, 32'heeeeeeee);
    end

    // T6: reset drops half a cycle before a pending write edge
    wr(5'd3, 32'h55555555);
    rd("t6_prefill", 5'd3, 32'h55555555, 5'd5, 32'haaaaaaaa);
    step();
    we     = 1'b1;
    waddr  = 5'd3;
    wdata  = 32'h12345678;
    raddr1 = 5'd3;
    raddr2 = 5'd5;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp("t6_reset_immediate", 1'b0, 32'h0);
    push_exp("t6_reset_immediate", 1'b1, 32'h0);
    ->chk_ev;
    step();
    we    = 1'b0;
    rst_n = 1'b1;
    step();
    rd("t6_after_release", 5'd3, 32'h0, 5'd5, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
